cvtwd: RTL and testbench

- Converts an IEEE-754 binary64 value into a 32-bit signed integer. This implements the MIPS cvt.w.d instruction under the FCSR rounding mode, the inverse of the existing cvt.d.w conversion.
- Multicycle FP-unit block with valid/ready on both sides.
- Iterative log-step right shifter with guard/sticky tracking, then one rounding cycle.
- Special operands (zero, NaN, Inf, out-of-range) take a short path.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/round_incr.sv | 22 ++
 rtl/cvtwd.sv | 162 ++++++++++++++++
 tb/tb_cvtwd.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 constants and encodings for the FP conversion blocks.
package fp_pkg;
  localparam int NEXP_D = 11;
  localparam int NSIG_D = 52;
  localparam int BIAS_D = 2 ** (NEXP_D - 1) - 1;

  localparam int FLAG_INEXACT = 0;
  localparam int FLAG_INVALID = 1;

  typedef enum logic [1:0] {
    RM_RN = 2'd0,
    RM_RZ = 2'd1,
    RM_RP = 2'd2,
    RM_RM = 2'd3
  } rmode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int fp_bias(input int nexp);
    return 2 ** (nexp - 1) - 1;
  endfunction
endpackage

// File: rtl/round_incr.sv
// Round-increment decision from rounding mode, sign, lsb, guard and sticky.
module round_incr
  import fp_pkg::*;
(
  input  logic [1:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       inc
);
  always_comb begin
    inc = 1'b0;
    case (rmode_t'(rm))
      RM_RN:   inc = guard & (sticky | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RP:   inc = ~sign & (guard | sticky);
      RM_RM:   inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
  end
endmodule

// File: rtl/cvtwd.sv
// binary64 -> signed INTn conversion: specials resolve in one cycle, others
// shift right over six log-steps with guard/sticky, then round in one cycle.
module cvtwd
  import fp_pkg::*;
#(
  parameter int INTn = 32,
  parameter int NEXP = NEXP_D,
  parameter int NSIG = NSIG_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in,
  input  logic [1:0]             rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INTn-1:0]        out,
  output logic                   invalid,
  output logic                   inexact
);
  localparam int WW = NSIG + 3;
  localparam int EW = NEXP + 2;
  localparam int MW = NSIG + 2;
  localparam logic signed [EW-1:0] BIAS_E  = EW'(fp_bias(NEXP));
  localparam logic signed [EW-1:0] INTN_E  = EW'(INTn);
  localparam logic signed [EW-1:0] NSIG_E  = EW'(NSIG);
  localparam logic signed [EW-1:0] SHMAX_E = EW'(NSIG + 2);
  localparam logic [INTn-1:0] MAXP = {1'b0, {(INTn-1){1'b1}}};
  localparam logic [INTn-1:0] MINN = {1'b1, {(INTn-1){1'b0}}};
  localparam logic [MW-1:0] LIM_N = MW'(1) << (INTn - 1);
  localparam logic [MW-1:0] LIM_P = LIM_N - MW'(1);

  state_t state, state_nxt;

  logic            sgn_in, frac_zero, exp_max;
  logic [NEXP-1:0] exp_f;
  logic [NSIG-1:0] frac;
  logic signed [EW-1:0] e_in, sh_full;
  logic [5:0]      sh_in;
  logic            short_path, short_inv;
  logic [INTn-1:0] short_out;

  assign sgn_in    = in[NEXP+NSIG];
  assign exp_f     = in[NEXP+NSIG-1:NSIG];
  assign frac      = in[NSIG-1:0];
  assign frac_zero = (frac == '0);
  assign exp_max   = &exp_f;
  // Subnormals are scaled as exponent 1-BIAS; the shift clamps at NSIG+2.
  assign e_in      = (exp_f == '0) ? (EW'(1) - BIAS_E) : ($signed({2'b00, exp_f}) - BIAS_E);
  assign sh_full   = NSIG_E - e_in;
  assign sh_in     = (sh_full > SHMAX_E) ? 6'(SHMAX_E) : sh_full[5:0];

  always_comb begin
    short_path = 1'b1;
    short_inv  = 1'b1;
    short_out  = sgn_in ? MINN : MAXP;
    if (exp_f == '0 && frac_zero) begin
      short_out = '0;
      short_inv = 1'b0;
    end else if (exp_max && !frac_zero) begin
      short_out = MAXP;
    end else if (e_in >= INTN_E) begin
      short_inv = 1'b1;
    end else if (e_in == INTN_E - EW'(1)) begin
      if (sgn_in && frac_zero) short_inv = 1'b0;
    end else begin
      short_path = 1'b0;
      short_inv  = 1'b0;
    end
  end

  logic [WW-1:0] w, w_sh;
  logic [5:0]    sh, stage_amt;
  logic [2:0]    cnt;
  logic          sgn_r, lost, inc, ovf;
  logic [1:0]    rm_r;
  logic [MW-1:0] mag;
  logic [INTn-1:0] rnd_out;

  assign stage_amt = 6'd32 >> cnt;
  assign lost      = |(w & ((WW'(1) << stage_amt) - WW'(1)));
  assign w_sh      = (w >> stage_amt) | WW'(lost);

  round_incr u_round_incr (
    .rm     (rm_r),
    .sign   (sgn_r),
    .lsb    (w[2]),
    .guard  (w[1]),
    .sticky (w[0]),
    .inc    (inc)
  );

  assign mag     = {1'b0, w[WW-1:2]} + MW'(inc);
  assign ovf     = sgn_r ? (mag > LIM_N) : (mag > LIM_P);
  assign rnd_out = sgn_r ? -mag[INTn-1:0] : mag[INTn-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = short_path ? DONE : SHIFT;
      SHIFT:   if (cnt == 3'd5) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w       <= '0;
      sh      <= '0;
      cnt     <= '0;
      sgn_r   <= 1'b0;
      rm_r    <= '0;
      out     <= '0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          w     <= {(exp_f != '0), frac, 2'b00};
          sh    <= sh_in;
          cnt   <= '0;
          sgn_r <= sgn_in;
          rm_r  <= rm;
          if (short_path) begin
            out     <= short_out;
            invalid <= short_inv;
            inexact <= 1'b0;
          end
        end
        SHIFT: begin
          if (sh[3'd5 - cnt]) w <= w_sh;
          cnt <= cnt + 3'd1;
        end
        ROUND: begin
          if (ovf) begin
            out     <= sgn_r ? MINN : MAXP;
            invalid <= 1'b1;
            inexact <= 1'b0;
          end else begin
            out     <= rnd_out;
            invalid <= 1'b0;
            inexact <= w[1] | w[0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cvtwd.sv
// Directed vector bench for cvtwd: conversion table plus backpressure and reset sequences.
module tb_cvtwd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] op = '0;
  logic [1:0]  rm = '0;
  logic        in_ready, out_valid, invalid, inexact;
  logic [31:0] res;

  int n_chk = 0;
  int n_fail = 0;

  cvtwd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (op),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (res),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] o, input logic [1:0] r,
                        output logic [31:0] ro, output logic iv, output logic ix,
                        output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    op = o;
    rm = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_valid_timeout: op %0h got no result within %0d cycles", o, lat);
    end
    ro = res;
    iv = invalid;
    ix = inexact;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] op;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vt[NV];

  initial begin
    logic [31:0] ro;
    logic iv, ix;
    int lat;

    vt[0]  = '{64'h3FF0000000000000, 2'd0, 32'h00000001, 1'b0, 1'b0, 8}; // 1.0
    vt[1]  = '{64'h4004000000000000, 2'd0, 32'h00000002, 1'b0, 1'b1, 8}; // 2.5 RN
    vt[2]  = '{64'h4004000000000000, 2'd2, 32'h00000003, 1'b0, 1'b1, 8}; // 2.5 RP
    vt[3]  = '{64'h4004000000000000, 2'd1, 32'h00000002, 1'b0, 1'b1, 8}; // 2.5 RZ
    vt[4]  = '{64'hC004000000000000, 2'd3, 32'hFFFFFFFD, 1'b0, 1'b1, 8}; // -2.5 RM
    vt[5]  = '{64'hC1E0000000000000, 2'd0, 32'h80000000, 1'b0, 1'b0, 1}; // -2^31
    vt[6]  = '{64'h41E0000000000000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 1}; // 2^31
    vt[7]  = '{64'h41DFFFFFFFE00000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 8}; // 2^31-0.5 RN
    vt[8]  = '{64'h41DFFFFFFFE00000, 2'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 8}; // 2^31-0.5 RZ
    vt[9]  = '{64'h7FF8000000000000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 1}; // NaN
    vt[10] = '{64'hFFF0000000000000, 2'd0, 32'h80000000, 1'b1, 1'b0, 1}; // -Inf
    vt[11] = '{64'h8000000000000000, 2'd0, 32'h00000000, 1'b0, 1'b0, 1}; // -0
    vt[12] = '{64'h3FE0000000000000, 2'd0, 32'h00000000, 1'b0, 1'b1, 8}; // 0.5 RN
    vt[13] = '{64'h3FE0000000000000, 2'd2, 32'h00000001, 1'b0, 1'b1, 8}; // 0.5 RP
    vt[14] = '{64'h0000000000000001, 2'd2, 32'h00000001, 1'b0, 1'b1, 8}; // min sub RP
    vt[15] = '{64'h0000000000000001, 2'd3, 32'h00000000, 1'b0, 1'b1, 8}; // min sub RM
    vt[16] = '{64'hBFE8000000000000, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 8}; // -0.75 RN
    vt[17] = '{64'h41DFFFFFFFC00000, 2'd0, 32'h7FFFFFFF, 1'b0, 1'b0, 8}; // 2^31-1 exact
    vt[18] = '{64'hC1E0000000000001, 2'd0, 32'h80000000, 1'b1, 1'b0, 1}; // just below -2^31
    vt[19] = '{64'hBFF8000000000000, 2'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 8}; // -1.5 RN
    vt[20] = '{64'hBFE0000000000000, 2'd0, 32'h00000000, 1'b0, 1'b1, 8}; // -0.5 RN -> +0
    vt[21] = '{64'hBFE0000000000000, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b1, 8}; // -0.5 RM

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out", res, 0);
    chk("reset_flags", {invalid, inexact}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].op, vt[i].rm, ro, iv, ix, lat);
      chk($sformatf("v%0d_out", i), ro, vt[i].res);
      chk($sformatf("v%0d_invalid", i), iv, vt[i].inv);
      chk($sformatf("v%0d_inexact", i), ix, vt[i].inx);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      handshake();
    end

    // Backpressure: result must hold and a second operand must be ignored.
    run_op(64'h4004000000000000, 2'd2, ro, iv, ix, lat);
    chk("bp_first_out", ro, 32'h3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      op = 64'h3FF0000000000000;
      rm = 2'd0;
      in_valid = 1'b1;
      chk($sformatf("bp_hold_out_%0d", k), res, 32'h3);
      chk($sformatf("bp_hold_flags_%0d", k), {invalid, inexact}, 2'b01);
      chk($sformatf("bp_hold_valid_%0d", k), out_valid, 1);
      chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_no_second_%0d", k), out_valid, 0);
      chk($sformatf("bp_idle_%0d", k), in_ready, 1);
    end

    // Reset during SHIFT aborts the conversion.
    @(negedge clk);
    op = 64'h3FF0000000000000;
    rm = 2'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'h4004000000000000, 2'd2, ro, iv, ix, lat);
    chk("post_rst_out", ro, 32'h3);
    chk("post_rst_flags", {iv, ix}, 2'b01);
    chk("post_rst_latency", lat, 8);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
